// File: rtl/mqc_fmap_collector_pkg.sv
// Shared types for the quantized feature-map collector: stream widths,
// the input beat bundle and the read-side state encoding.
package mqc_fmap_collector_pkg;

  localparam int FEATURE_MAP_RESOLUTION = 8;
  localparam int FEATURE_MAP_ADDRWIDE   = 9;

  typedef struct packed {
    logic                                     valid;
    logic signed [FEATURE_MAP_RESOLUTION-1:0] data;
    logic [FEATURE_MAP_ADDRWIDE-1:0]          addr;
    logic                                     ready;
  } mqc_stream_t;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_e;

endpackage

// File: rtl/fmap_bank.sv
// One frame of pixel storage: flop array, synchronous write, asynchronous read.
module fmap_bank #(
  parameter int NPIX = 377,
  parameter int DW   = 8,
  parameter int AW   = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NPIX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < NPIX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < NPIX) ? mem[raddr] : '0;

endmodule

// File: rtl/mqc_fmap_collector.sv
// Collects one feature map per frame into ping-pong banks and replays each
// committed frame in raster order over a valid/ready stream.
module mqc_fmap_collector
  import mqc_fmap_collector_pkg::*;
#(
  parameter int F_IN_H = 13,
  parameter int F_IN_W = 29
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              mqcRec_valid_i,
  input  logic [FEATURE_MAP_RESOLUTION-1:0] mqcRec_data_i,
  input  logic [FEATURE_MAP_ADDRWIDE-1:0]   mqcRec_addr_i,
  output logic                              mqcRec_ready_o,
  output logic                              fmap_valid_o,
  output logic [FEATURE_MAP_RESOLUTION-1:0] fmap_data_o,
  output logic [FEATURE_MAP_ADDRWIDE-1:0]   fmap_addr_o,
  output logic                              fmap_last_o,
  input  logic                              fmap_ready_i,
  output logic                              frame_done_o,
  output logic                              err_addr_o
);

  localparam int NPIX = F_IN_H * F_IN_W;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int DW   = FEATURE_MAP_RESOLUTION;
  localparam int AW   = FEATURE_MAP_ADDRWIDE;

  rd_state_e     state, state_n;
  logic          wr_bank, rd_bank;
  logic [1:0]    bank_full, bank_full_n;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [CW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          err_addr;
  logic [DW-1:0] bank_rdata [2];
  mqc_stream_t   in_s;
  logic          in_range, wr_en, commit, load, rel;

  // Ready depends only on registered bank occupancy.
  assign in_s = '{valid: mqcRec_valid_i, data: mqcRec_data_i,
                  addr: mqcRec_addr_i, ready: !bank_full[wr_bank]};

  assign in_range = int'(in_s.addr) < NPIX;
  assign wr_en    = in_s.valid && in_s.ready && in_range;
  assign commit   = wr_en && (wr_cnt == CW'(NPIX - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(.NPIX(NPIX), .DW(DW), .AW(AW)) u_bank (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .we    (wr_en && (wr_bank == 1'(b))),
      .waddr (in_s.addr),
      .wdata (in_s.data),
      .raddr (AW'(rd_cnt)),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  // rd_cnt is 0 in IDLE, so the first load and every later load share one path.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    rel     = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          load    = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (fmap_ready_i) begin
          if (out_addr == CW'(NPIX - 1)) begin
            rel     = 1'b1;
            state_n = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Commit and release always target different banks when they coincide.
  always_comb begin
    bank_full_n = bank_full;
    if (commit) bank_full_n[wr_bank] = 1'b1;
    if (rel)    bank_full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      err_addr  <= 1'b0;
    end else begin
      bank_full <= bank_full_n;
      if (wr_en)  wr_cnt  <= commit ? '0 : wr_cnt + 1'b1;
      if (commit) wr_bank <= !wr_bank;
      if (in_s.valid && in_s.ready && !in_range) err_addr <= 1'b1;
      if (load) begin
        out_addr <= rd_cnt;
        out_data <= rd_bank ? bank_rdata[1] : bank_rdata[0];
        rd_cnt   <= rd_cnt + 1'b1;
      end
      if (rel) begin
        rd_cnt  <= '0;
        rd_bank <= !rd_bank;
      end
    end
  end

  assign mqcRec_ready_o = in_s.ready;
  assign fmap_valid_o   = (state == STREAM);
  assign fmap_data_o    = out_data;
  assign fmap_addr_o    = AW'(out_addr);
  assign fmap_last_o    = fmap_valid_o && (out_addr == CW'(NPIX - 1));
  assign frame_done_o   = rel;
  assign err_addr_o     = err_addr;

endmodule
